bit_brick: RTL and testbench



---
 rtl/bit_brick_pkg.sv | 17 +
 rtl/bit_brick_if.sv | 27 ++
 rtl/bit_brick_core.sv | 26 ++
 rtl/bit_brick.sv | 62 ++++++
 tb/tb_bit_brick.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/bit_brick_pkg.sv
// Shared constants, types and operand-extension helper for the bit_brick multiplier primitive.
package bit_brick_pkg;

  localparam int BB_IN_W  = 2;
  localparam int BB_EXT_W = 3;
  localparam int BB_P_W   = 6;
  localparam int BB_SH_W  = 3;

  typedef logic signed [BB_EXT_W-1:0] bb_ext_t;
  typedef logic signed [BB_P_W-1:0]   bb_prod_t;

  // The sign flag decides whether the top operand bit is replicated or zero-filled.
  function automatic bb_ext_t ext_operand(logic [BB_IN_W-1:0] v, logic s);
    return signed'({s & v[BB_IN_W-1], v});
  endfunction

endpackage

// File: rtl/bit_brick_if.sv
// Operand/result bundle for bit_brick; shamt and p_sh exist only when BIT_BRICK_SHIFT_EN is defined.
interface bit_brick_if
`ifdef BIT_BRICK_SHIFT_EN
  #(parameter int OUT_W = 16)
`endif
  ;
  import bit_brick_pkg::*;

  logic                 in_valid;
  logic [BB_IN_W-1:0]   x;
  logic [BB_IN_W-1:0]   y;
  logic                 sx;
  logic                 sy;
  bb_prod_t             p;
  logic                 out_valid;
`ifdef BIT_BRICK_SHIFT_EN
  logic [BB_SH_W-1:0]   shamt;
  logic signed [OUT_W-1:0] p_sh;

  modport master (output in_valid, x, y, sx, sy, shamt, input p, out_valid, p_sh);
  modport slave  (input in_valid, x, y, sx, sy, shamt, output p, out_valid, p_sh);
`else
  modport master (output in_valid, x, y, sx, sy, input p, out_valid);
  modport slave  (input in_valid, x, y, sx, sy, output p, out_valid);
`endif

endinterface

// File: rtl/bit_brick_core.sv
// Combinational core: widens each 2-bit operand by its sign flag and forms the 6-bit signed product.
module bit_brick_core
  import bit_brick_pkg::*;
(
  input  logic [BB_IN_W-1:0] x,
  input  logic [BB_IN_W-1:0] y,
  input  logic               sx,
  input  logic               sy,
  output bb_prod_t           prod
);

  bb_ext_t  xe;
  bb_ext_t  ye;
  bb_prod_t xw;
  bb_prod_t yw;

  // Operands lie in -2..3, so the product (-6..9) always fits in 6 bits.
  always_comb begin
    xe   = ext_operand(x, sx);
    ye   = ext_operand(y, sy);
    xw   = bb_prod_t'(xe);
    yw   = bb_prod_t'(ye);
    prod = xw * yw;
  end

endmodule

// File: rtl/bit_brick.sv
// Registered 2x2 bit-fusion multiplier brick; BIT_BRICK_SHIFT_EN adds a shifted, sign-extended output p_sh.
module bit_brick
  import bit_brick_pkg::*;
#(
  parameter int OUT_W = 16
) (
  input logic       clk,
  input logic       rst_n,
  bit_brick_if.slave bus
);

  if (OUT_W < 13) begin : g_out_w_chk
    $error("bit_brick: OUT_W must be at least 13");
  end

  bb_prod_t prod_p0;
  bb_prod_t p_p1;
  logic     vld_p1;

  bit_brick_core u_core (
    .x    (bus.x),
    .y    (bus.y),
    .sx   (bus.sx),
    .sy   (bus.sy),
    .prod (prod_p0)
  );

  // p0 -> p1: capture on valid only, so idle operands never reach p.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_p1   <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= bus.in_valid;
      if (bus.in_valid) p_p1 <= prod_p0;
    end
  end

  assign bus.p         = p_p1;
  assign bus.out_valid = vld_p1;

`ifdef BIT_BRICK_SHIFT_EN
  logic signed [OUT_W-1:0] p_sh_p1;

  function automatic logic signed [OUT_W-1:0] place_prod(bb_prod_t v, logic [BB_SH_W-1:0] sh);
    logic signed [OUT_W-1:0] w;
    w = OUT_W'(v);
    return w <<< sh;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_sh_p1 <= '0;
    end else if (bus.in_valid) begin
      p_sh_p1 <= place_prod(prod_p0, bus.shamt);
    end
  end

  assign bus.p_sh = p_sh_p1;
`endif

endmodule

// File: tb/tb_bit_brick.sv
// Directed-vector bench for bit_brick: table vectors, async reset, and a full-rate 64-case sweep.
module tb_bit_brick;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

`ifdef BIT_BRICK_SHIFT_EN
  bit_brick_if #(.OUT_W(16)) bus ();
`else
  bit_brick_if bus ();
`endif

  bit_brick #(.OUT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic       vld;
    logic [1:0] x;
    logic [1:0] y;
    logic       sx;
    logic       sy;
    int         exp_p;
    logic       exp_v;
  } vec_t;

  function automatic int ref_prod(logic [1:0] x, logic [1:0] y, logic sx, logic sy);
    int a;
    int b;
    a = int'(x);
    b = int'(y);
    if (sx && x[1]) a = a - 4;
    if (sy && y[1]) b = b - 4;
    return a * b;
  endfunction

  task automatic chk(string name, int act, int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(logic vld, logic [1:0] x, logic [1:0] y, logic sx, logic sy, logic [2:0] sh);
    bus.in_valid = vld;
    bus.x  = x;
    bus.y  = y;
    bus.sx = sx;
    bus.sy = sy;
`ifdef BIT_BRICK_SHIFT_EN
    bus.shamt = sh;
`else
    if (sh != 3'd0) bus.x = x;
`endif
  endtask

  vec_t tbl[7];
  int   last_p;

  initial begin
    tbl[0] = '{1'b1, 2'b01, 2'b11, 1'b0, 1'b1, -1, 1'b1};
    tbl[1] = '{1'b1, 2'b11, 2'b11, 1'b0, 1'b1, -3, 1'b1};
    tbl[2] = '{1'b0, 2'b00, 2'b00, 1'b0, 1'b0, -3, 1'b0};
    tbl[3] = '{1'b1, 2'b11, 2'b11, 1'b0, 1'b0,  9, 1'b1};
    tbl[4] = '{1'b1, 2'b10, 2'b11, 1'b1, 1'b0, -6, 1'b1};
    tbl[5] = '{1'b1, 2'b10, 2'b10, 1'b1, 1'b1,  4, 1'b1};
    tbl[6] = '{1'b0, 2'b00, 2'b00, 1'b0, 1'b0,  4, 1'b0};

    // Reset with valid operands present: outputs must stay clear.
    drive(1'b1, 2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 3'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_p", int'(bus.p), 0);
    chk("reset_vld", int'(bus.out_valid), 0);

    // Get a nonzero result, then assert reset between edges.
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 2'b11, 2'b11, 1'b0, 1'b0, 3'd0);
    @(posedge clk);
    #1;
    chk("pre_async_p", int'(bus.p), 9);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_p", int'(bus.p), 0);
    chk("async_vld", int'(bus.out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table vectors; idle rows get random operands to show they are ignored.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (tbl[i].vld)
        drive(1'b1, tbl[i].x, tbl[i].y, tbl[i].sx, tbl[i].sy, 3'd0);
      else
        drive(1'b0, 2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 3'($urandom));
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_p", i), int'(bus.p), tbl[i].exp_p);
      chk($sformatf("tbl%0d_vld", i), int'(bus.out_valid), int'(tbl[i].exp_v));
    end

`ifdef BIT_BRICK_SHIFT_EN
    @(negedge clk);
    drive(1'b1, 2'b11, 2'b11, 1'b0, 1'b1, 3'd4);
    @(posedge clk);
    #1;
    chk("shift4_p_sh", int'(bus.p_sh), -48);
    @(negedge clk);
    drive(1'b1, 2'b11, 2'b11, 1'b0, 1'b1, 3'd0);
    @(posedge clk);
    #1;
    chk("shift0_p_sh", int'(bus.p_sh), int'(bus.p));
    chk("shift0_p", int'(bus.p), -3);
`endif

    // Full-rate sweep of all 64 operand/sign combinations with a mid-sweep reset.
    last_p = 0;
    for (int i = 0; i < 64; i++) begin
      logic [5:0] c;
      logic [2:0] sh;
      int         e;
      c  = 6'(i);
      sh = 3'($urandom_range(0, 7));
      e  = ref_prod(c[1:0], c[3:2], c[4], c[5]);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, c[1:0], c[3:2], c[4], c[5], sh);
      @(posedge clk);
      #1;
      chk($sformatf("sweep%0d_p", i), int'(bus.p), e);
      chk($sformatf("sweep%0d_vld", i), int'(bus.out_valid), 1);
`ifdef BIT_BRICK_SHIFT_EN
      chk($sformatf("sweep%0d_p_sh", i), int'(bus.p_sh), e * (1 << sh));
`endif
      if (i == 30) begin
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_p", int'(bus.p), 0);
        chk("mid_rst_vld", int'(bus.out_valid), 0);
`ifdef BIT_BRICK_SHIFT_EN
        chk("mid_rst_p_sh", int'(bus.p_sh), 0);
`endif
      end
      last_p = e;
    end

    // Drop valid after the sweep: last result holds.
    @(negedge clk);
    drive(1'b0, 2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 3'd0);
    @(posedge clk);
    #1;
    chk("post_sweep_hold_p", int'(bus.p), last_p);
    chk("post_sweep_vld", int'(bus.out_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
